// File: rtl/prog_sequencer.sv
// prog_sequencer: batch controller for the BasicProcessor Start/Ack handshake.
// It launches programs 0..NumProgs back-to-back and presents each program's
// index on ProgSel. It measures each run in cycles and aborts the batch through
// a watchdog.
//
// Ports:
//   Clk         - clock, rising edge
//   Reset       - asynchronous active-low reset
//   Go          - batch request, accepted only while idle
//   NumProgs    - index of the last program to run (sampled on Go)
//   TimeoutLim  - watchdog limit in cycles, 0 disables (sampled on Go)
//   Ack         - processor done flag
//   Start       - start pulse to the processor (START_CYC cycles per launch)
//   ProgSel     - index of the program being launched or run
//   Busy        - controller is not idle
//   ResultValid - one-cycle pulse when RunCycles is updated
//   RunCycles   - length of the last finished or aborted run
//   Done        - batch completed normally (cleared on next accepted Go)
//   TimedOut    - batch aborted by watchdog (cleared on next accepted Go)
module prog_sequencer #(
    parameter int unsigned PROG_W    = 2,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned START_CYC = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Go,
    input  logic [PROG_W-1:0] NumProgs,
    input  logic [CNT_W-1:0]  TimeoutLim,
    input  logic              Ack,
    output logic              Start,
    output logic [PROG_W-1:0] ProgSel,
    output logic              Busy,
    output logic              ResultValid,
    output logic [CNT_W-1:0]  RunCycles,
    output logic              Done,
    output logic              TimedOut
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        NEXT,
        FINISH,
        ABORT
    } state_e;

    localparam logic [3:0] LAUNCH_LAST = 4'(START_CYC - 1);

    state_e            state_q, state_d;
    logic [3:0]        launch_cnt_q, launch_cnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  lim_q, lim_d;
    logic [PROG_W-1:0] num_q, num_d;
    logic [PROG_W-1:0] sel_q, sel_d;
    logic              start_q, start_d;
    logic              busy_q, busy_d;
    logic              rv_q, rv_d;
    logic [CNT_W-1:0]  run_cycles_q, run_cycles_d;
    logic              done_q, done_d;
    logic              to_q, to_d;
    logic              wd_hit;

    // A limit of zero disables the watchdog; Ack has priority over it in RUN.
    assign wd_hit = (lim_q != '0) && (cnt_q == lim_q);

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            launch_cnt_q <= '0;
            cnt_q        <= '0;
            lim_q        <= '0;
            num_q        <= '0;
            sel_q        <= '0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            rv_q         <= 1'b0;
            run_cycles_q <= '0;
            done_q       <= 1'b0;
            to_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            launch_cnt_q <= launch_cnt_d;
            cnt_q        <= cnt_d;
            lim_q        <= lim_d;
            num_q        <= num_d;
            sel_q        <= sel_d;
            start_q      <= start_d;
            busy_q       <= busy_d;
            rv_q         <= rv_d;
            run_cycles_q <= run_cycles_d;
            done_q       <= done_d;
            to_q         <= to_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        launch_cnt_d = launch_cnt_q;
        cnt_d        = cnt_q;
        lim_d        = lim_q;
        num_d        = num_q;
        sel_d        = sel_q;
        case (state_q)
            IDLE: begin
                if (Go) begin
                    num_d        = NumProgs;
                    lim_d        = TimeoutLim;
                    sel_d        = '0;
                    launch_cnt_d = '0;
                    state_d      = LAUNCH;
                end
            end
            LAUNCH: begin
                // Ack is ignored here: the core holds its PC in reset while Start is high.
                if (launch_cnt_q == LAUNCH_LAST) begin
                    cnt_d   = CNT_W'(1);
                    state_d = RUN;
                end else begin
                    launch_cnt_d = launch_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (Ack) begin
                    state_d = NEXT;
                end else if (wd_hit) begin
                    state_d = ABORT;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            NEXT: begin
                if (sel_q == num_q) begin
                    state_d = FINISH;
                end else begin
                    sel_d        = sel_q + 1'b1;
                    launch_cnt_d = '0;
                    state_d      = LAUNCH;
                end
            end
            FINISH:  state_d = IDLE;
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs. Start and Busy follow the next state, so they line up
    // with the state they describe.
    always_comb begin
        start_d      = (state_d == LAUNCH);
        busy_d       = (state_d != IDLE);
        rv_d         = 1'b0;
        run_cycles_d = run_cycles_q;
        done_d       = done_q;
        to_d         = to_q;
        case (state_q)
            IDLE: begin
                if (Go) begin
                    done_d = 1'b0;
                    to_d   = 1'b0;
                end
            end
            RUN: begin
                if (Ack || wd_hit) begin
                    rv_d         = 1'b1;
                    run_cycles_d = cnt_q;
                end
            end
            FINISH:  done_d = 1'b1;
            ABORT:   to_d   = 1'b1;
            default: ;
        endcase
    end

    assign Start       = start_q;
    assign ProgSel     = sel_q;
    assign Busy        = busy_q;
    assign ResultValid = rv_q;
    assign RunCycles   = run_cycles_q;
    assign Done        = done_q;
    assign TimedOut    = to_q;

endmodule
